// File: rtl/feature_fetch_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : feature_fetch_unpack
//  Purpose  : Accepts wide words from the external read stream, unpacks each
//             into DATA_W-bit features and writes them one per cycle into the
//             feature_in memory. Alternates feature_in banks per fetch.
//  Revision : 1.0 - initial release
// ============================================================================
module feature_fetch_unpack #(
  parameter int IN_W      = 128,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 15,
  parameter int SIZE_W    = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE_W-1:0] feature_size,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [IN_W-1:0]   i_data,
  input  logic              i_valid,
  output logic              i_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              i_mem_select,
  output logic              busy,
  output logic              done
);

  // IN_W is expected to be an exact multiple of DATA_W.
  localparam int LANES  = IN_W / DATA_W;
  localparam int LANE_W = $clog2(LANES + 1);
  localparam int TOT_W  = 2 * SIZE_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_UNPACK = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t              state_q,   state_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [TOT_W-1:0]    rem_q,     rem_d;
  logic [LANE_W-1:0]   lane_q,    lane_d;
  logic [IN_W-1:0]     word_q,    word_d;
  logic                ready_q,   ready_d;
  logic                wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                sel_q,     sel_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;

  logic [TOT_W-1:0]    total_w;

  // Total features of the square map, computed at full product width.
  assign total_w = {{SIZE_W{1'b0}}, feature_size} * {{SIZE_W{1'b0}}, feature_size};

  // Select write-order lane idx of a word, honouring MSB_FIRST ordering.
  function automatic logic [DATA_W-1:0] lane_of(input logic [IN_W-1:0]   word,
                                                input logic [LANE_W-1:0] idx);
    logic [DATA_W-1:0] res;
    logic [LANE_W-1:0] sel;
    res = '0;
    sel = (MSB_FIRST != 0) ? (LANE_W'(LANES - 1) - idx) : idx;
    for (int k = 0; k < LANES; k++) begin
      if (sel == LANE_W'(k)) begin
        res = word[DATA_W*k +: DATA_W];
      end
    end
    return res;
  endfunction

  // Next-state and registered-output logic. Each write is issued one cycle
  // before it appears on the outputs, so the UNPACK state is exactly the set
  // of cycles in which wr_en is high.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    lane_d    = lane_q;
    word_d    = word_q;
    ready_d   = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (total_w != '0) begin
            state_d = S_LOAD;
            addr_d  = base_addr;
            rem_d   = total_w;
            busy_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            // Empty map: report completion without touching the bank.
            state_d = S_FINISH;
            done_d  = 1'b1;
          end
        end
      end

      S_LOAD: begin
        ready_d = 1'b1;
        if (i_valid && ready_q) begin
          // Lane 0 is issued on the capture edge itself, so the lane counter
          // restarts at 1 rather than 0.
          word_d    = i_data;
          wr_en_d   = 1'b1;
          wr_data_d = lane_of(i_data, '0);
          wr_addr_d = addr_q;
          addr_d    = addr_q + ADDR_W'(1);
          rem_d     = rem_q - TOT_W'(1);
          lane_d    = LANE_W'(1);
          ready_d   = 1'b0;
          state_d   = S_UNPACK;
        end
      end

      S_UNPACK: begin
        if (rem_q == '0) begin
          // Last feature is on the outputs now; leftover lanes are dropped.
          state_d = S_FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          sel_d   = ~sel_q;
        end else if (lane_q == LANE_W'(LANES)) begin
          state_d = S_LOAD;
          ready_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_data_d = lane_of(word_q, lane_q);
          wr_addr_d = addr_q;
          addr_d    = addr_q + ADDR_W'(1);
          rem_d     = rem_q - TOT_W'(1);
          lane_d    = lane_q + LANE_W'(1);
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      lane_q    <= '0;
      word_q    <= '0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      lane_q    <= lane_d;
      word_q    <= word_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign i_ready      = ready_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign i_mem_select = sel_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_feature_fetch_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_feature_fetch_unpack
//  Purpose  : Scoreboard bench for feature_fetch_unpack (default parameters).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_feature_fetch_unpack;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    feature_size = '0;
  logic [14:0]   base_addr = '0;
  logic [127:0]  i_data = '0;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [14:0]   wr_addr;
  logic [15:0]   wr_data;
  logic          wr_en;
  logic          i_mem_select;
  logic          busy;
  logic          done;

  feature_fetch_unpack dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .feature_size (feature_size),
    .base_addr    (base_addr),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .i_ready      (i_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .i_mem_select (i_mem_select),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] W0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [127:0] W1 = 128'h000F_000E_000D_000C_000B_000A_0009_0008;
  localparam logic [127:0] W2 = 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0;

  typedef struct {
    logic [14:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t    exp_wr[$];
  bit     exp_sel[$];
  longint wr_log[$];
  longint done_log[$];

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;
  longint hs_cyc  = 0;
  longint start_cyc = 0;
  bit     sel_model = 1'b0;

  // cycle counter: value read at a negedge names the current cycle
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [14:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_wr.push_back(e);
  endtask

  // Expected writes of a fetch with sequential data, plus its done event.
  task automatic push_fetch(input logic [14:0] base, input logic [15:0] d0, input int cnt);
    for (int i = 0; i < cnt; i++) push_wr(base + 15'(i), d0 + 16'(i));
    if (cnt > 0) sel_model = ~sel_model;
    exp_sel.push_back(sel_model);
  endtask

  task automatic pulse_start(input logic [7:0] n, input logic [14:0] base);
    @(negedge clk);
    feature_size = n;
    base_addr    = base;
    start        = 1'b1;
    start_cyc    = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Deliver one word. With gap>0, i_valid stays low for gap cycles of LOAD
  // before being raised. Returns at the negedge preceding the handshake edge.
  task automatic feed(input logic [127:0] w, input int gap);
    if (gap > 0) begin
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        i_valid = 1'b0;
        if (i_ready) break;
      end
      for (int k = 1; k < gap; k++) begin
        @(negedge clk);
        i_valid = 1'b0;
      end
    end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = w;
      if (i_ready) begin
        hs_cyc = cyc;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL feed_timeout: got no i_ready expected i_ready=1");
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      i_valid = 1'b0;
      if (done) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL done_timeout: got no done expected done=1");
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_i_ready"}, i_ready, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_mem_select"}, i_mem_select, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Monitor: compares every presented write and done pulse to the scoreboard.
  initial begin
    wr_t e;
    bit  s;
    forever begin
      @(negedge clk);
      if (wr_en) begin
        wr_log.push_back(cyc);
        n_tests++;
        if (exp_wr.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr=%h data=%h expected no write", wr_addr, wr_data);
        end else begin
          e = exp_wr.pop_front();
          if (wr_addr !== e.a || wr_data !== e.d) begin
            n_fail++;
            $display("FAIL write: got addr=%h data=%h expected addr=%h data=%h",
                     wr_addr, wr_data, e.a, e.d);
          end
        end
      end
      if (done) begin
        done_log.push_back(cyc);
        n_tests++;
        if (exp_sel.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected done=0");
        end else begin
          s = exp_sel.pop_front();
          if (i_mem_select !== s || busy !== 1'b0 || exp_wr.size() != 0) begin
            n_fail++;
            $display("FAIL done_state: got sel=%0b busy=%0b pending=%0d expected sel=%0b busy=0 pending=0",
                     i_mem_select, busy, exp_wr.size(), s);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int n0;
    int d0;
    int cnt;

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // N=4, two words, valid held high
    n0 = wr_log.size();
    push_fetch(15'h0100, 16'h0000, 16);
    pulse_start(8'd4, 15'h0100);
    feed(W0, 0);
    d0 = int'(hs_cyc);
    feed(W1, 0);
    wait_done();
    @(negedge clk);
    check("t1_write_count", wr_log.size() - n0, 16);
    check("t1_first_latency", wr_log[n0] - longint'(d0), 1);
    check("t1_back_to_back", wr_log[n0+1] - wr_log[n0], 1);
    check("t1_load_gap", wr_log[n0+8] - wr_log[n0+7], 2);
    check("t1_done_after_last", done_log[done_log.size()-1] - wr_log[wr_log.size()-1], 1);
    check("t1_sel_after", i_mem_select, 1);

    // N=3: partial second word, lanes 1..7 discarded
    n0 = wr_log.size();
    push_fetch(15'h0300, 16'h0000, 9);
    pulse_start(8'd3, 15'h0300);
    feed(W0, 0);
    feed(W1, 0);
    wait_done();
    @(negedge clk);
    check("t2_write_count", wr_log.size() - n0, 9);
    check("t2_done_after_last", done_log[done_log.size()-1] - wr_log[wr_log.size()-1], 1);
    check("t2_sel_after", i_mem_select, 0);

    // Address wrap at 2^ADDR_W
    sel_model = ~sel_model;
    push_wr(15'h7FFE, 16'h00A0);
    push_wr(15'h7FFF, 16'h00A1);
    push_wr(15'h0000, 16'h00A2);
    push_wr(15'h0001, 16'h00A3);
    exp_sel.push_back(sel_model);
    pulse_start(8'd2, 15'h7FFE);
    feed(W2, 0);
    wait_done();

    // Stalling source plus a start pulse while busy
    n0 = wr_log.size();
    d0 = done_log.size();
    push_fetch(15'h0400, 16'h0000, 16);
    pulse_start(8'd4, 15'h0400);
    feed(W0, 2);
    @(posedge clk);
    #1;
    i_valid      = 1'b0;
    feature_size = 8'd1;
    base_addr    = 15'h7000;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    feed(W1, 2);
    wait_done();
    repeat (12) @(negedge clk);
    check("t4_write_count", wr_log.size() - n0, 16);
    check("t4_stall_gap", wr_log[n0+8] - wr_log[n0+7], 4);
    check("t4_done_count", done_log.size() - d0, 1);

    // N=0: done only, bank held
    n0 = wr_log.size();
    exp_sel.push_back(sel_model);
    pulse_start(8'd0, 15'h0700);
    wait_done();
    @(negedge clk);
    check("t5_done_latency", done_log[done_log.size()-1] - start_cyc, 1);
    check("t5_no_writes", wr_log.size() - n0, 0);
    check("t5_sel_held", i_mem_select, 0);

    // Back-to-back N=2 fetches toggle the bank; start during done ignored
    push_fetch(15'h0500, 16'h00A0, 4);
    pulse_start(8'd2, 15'h0500);
    feed(W2, 0);
    wait_done();
    feature_size = 8'd2;
    base_addr    = 15'h0580;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_sel_first", i_mem_select, 1);
    check("t6_done_start_ignored", busy, 0);
    push_fetch(15'h0510, 16'h00A0, 4);
    pulse_start(8'd2, 15'h0510);
    feed(W2, 0);
    wait_done();
    @(negedge clk);
    check("t6_sel_second", i_mem_select, 0);

    // Reset after the third write of an N=4 fetch
    push_wr(15'h0200, 16'h0000);
    push_wr(15'h0201, 16'h0001);
    push_wr(15'h0202, 16'h0002);
    pulse_start(8'd4, 15'h0200);
    feed(W0, 0);
    cnt = 0;
    for (int k = 0; k < 50 && cnt < 3; k++) begin
      @(negedge clk);
      i_valid = 1'b0;
      if (wr_en) cnt++;
    end
    check("t7_writes_before_rst", cnt, 3);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("t7_after_rst");
    rst = 1'b0;
    sel_model = 1'b0;
    repeat (4) @(negedge clk);
    push_fetch(15'h0210, 16'h0000, 4);
    pulse_start(8'd2, 15'h0210);
    feed(W0, 0);
    wait_done();
    repeat (4) @(negedge clk);
    check("t7_sel_after_refetch", i_mem_select, 1);

    check("scoreboard_empty", exp_wr.size() + exp_sel.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
